l1_mem_burst_arbiter: RTL and testbench

Three-master to one-slave Wishbone burst arbiter. It shares the SoC data port (cpu2dmux side) between the I$ refill master, the D$ refill/writeback master and the core's uncached "others" master. Grant is held for a whole transaction: a single access, or a burst of bl beats. Master selection is round-robin, so no master starves.

---
 rtl/l1_mem_pkg.sv | 21 ++
 rtl/rr_arbiter3.sv | 35 +++
 rtl/l1_mem_burst_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_l1_mem_burst_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_mem_pkg.sv
// Shared definitions for the L1 memory-side Wishbone arbitration blocks.
// Master indices, FSM encoding and default bus widths.
package l1_mem_pkg;

    localparam int unsigned L1_ADDR_W = 32;
    localparam int unsigned L1_DATA_W = 32;
    localparam int unsigned L1_BL_W   = 10;
    localparam int unsigned L1_NUM_M  = 3;

    localparam logic [1:0] M_ICACHE = 2'd0;
    localparam logic [1:0] M_DCACHE = 2'd1;
    localparam logic [1:0] M_OTHERS = 2'd2;
    localparam logic [1:0] M_NONE   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter3.sv
// Combinational three-way round-robin picker: scans from the master after
// last_grant and returns the first requester, one-hot and encoded.
module rr_arbiter3
    import l1_mem_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] last_grant,
    output logic [2:0] gnt_oh,
    output logic [1:0] gnt_idx
);

    logic [1:0] first;
    logic [2:0] sum;
    logic [1:0] idx;
    logic       found;

    always_comb begin
        first   = (last_grant >= M_OTHERS) ? M_ICACHE : last_grant + 2'd1;
        gnt_oh  = '0;
        gnt_idx = M_NONE;
        found   = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            sum = 3'(first) + 3'(k);
            idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : 2'(sum);
            if (!found && req[idx]) begin
                found   = 1'b1;
                gnt_oh  = 3'b001 << idx;
                gnt_idx = idx;
            end
        end
    end

endmodule

// File: rtl/l1_mem_burst_arbiter.sv
// Three-master to one-slave Wishbone burst arbiter (icache, dcache, others).
// Ownership is held for a whole transaction, selection is round-robin.
module l1_mem_burst_arbiter
    import l1_mem_pkg::*;
#(
    parameter  int unsigned ADDR_W = L1_ADDR_W,
    parameter  int unsigned DATA_W = L1_DATA_W,
    parameter  int unsigned BL_W   = L1_BL_W,
    parameter  int unsigned NUM_M  = L1_NUM_M,
    localparam int unsigned SEL_W  = DATA_W / 8
)(
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [BL_W-1:0]   m0_bl_i,
    input  logic              m0_bry_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_dat_o,

    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    input  logic [SEL_W-1:0]  m1_sel_i,
    input  logic [BL_W-1:0]   m1_bl_i,
    input  logic              m1_bry_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_dat_o,

    input  logic              m2_cyc_i,
    input  logic              m2_stb_i,
    input  logic              m2_we_i,
    input  logic [ADDR_W-1:0] m2_adr_i,
    input  logic [DATA_W-1:0] m2_dat_i,
    input  logic [SEL_W-1:0]  m2_sel_i,
    output logic              m2_ack_o,
    output logic [DATA_W-1:0] m2_dat_o,

    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    output logic [SEL_W-1:0]  s_sel_o,
    output logic [BL_W-1:0]   s_bl_o,
    output logic              s_bry_o,
    input  logic              s_ack_i,
    input  logic [DATA_W-1:0] s_dat_i,

    output logic [1:0]        grant_o
);

    state_e          state;
    state_e          state_nxt;
    logic [1:0]      grant_nxt;
    logic [1:0]      last_grant;
    logic [1:0]      last_grant_nxt;
    logic [BL_W-1:0] beat_cnt;
    logic [BL_W-1:0] beat_cnt_nxt;
    logic [BL_W-1:0] load_cnt;
    logic [NUM_M-1:0] req;
    logic [2:0]      win_oh;
    logic [1:0]      win_idx;
    logic            busy;

    assign req = {m2_cyc_i & m2_stb_i, m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

    rr_arbiter3 u_rr (
        .req        (req),
        .last_grant (last_grant),
        .gnt_oh     (win_oh),
        .gnt_idx    (win_idx)
    );

    // Beat count for the winner; a zero length is still one beat.
    always_comb begin
        load_cnt = BL_W'(1);
        case (win_idx)
            M_ICACHE: if (m0_bl_i != '0) load_cnt = m0_bl_i;
            M_DCACHE: if (m1_bl_i != '0) load_cnt = m1_bl_i;
            default:  load_cnt = BL_W'(1);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            grant_o    <= M_NONE;
            last_grant <= M_OTHERS;
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            grant_o    <= grant_nxt;
            last_grant <= last_grant_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant_o;
        last_grant_nxt = last_grant;
        beat_cnt_nxt   = beat_cnt;
        case (state)
            ST_IDLE: begin
                if (|win_oh) begin
                    grant_nxt    = win_idx;
                    beat_cnt_nxt = load_cnt;
                    state_nxt    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s_ack_i && beat_cnt != '0) begin
                    beat_cnt_nxt = beat_cnt - BL_W'(1);
                end
                if (s_ack_i && beat_cnt == BL_W'(1)) begin
                    state_nxt      = ST_DONE;
                    grant_nxt      = M_NONE;
                    last_grant_nxt = grant_o;
                end else if (!s_cyc_o) begin
                    // owner abandoned the transaction before its last beat
                    state_nxt = ST_DONE;
                    grant_nxt = M_NONE;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Slave-side mux and ack/data return; everything idles at zero.
    assign busy = (state == ST_BUSY) && !reset;

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_bl_o   = '0;
        s_bry_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        m2_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        m2_dat_o = '0;
        if (busy) begin
            case (grant_o)
                M_ICACHE: begin
                    s_cyc_o  = m0_cyc_i;
                    s_stb_o  = m0_stb_i;
                    s_adr_o  = m0_adr_i;
                    s_sel_o  = '1;
                    s_bl_o   = m0_bl_i;
                    s_bry_o  = m0_bry_i;
                    m0_ack_o = s_ack_i;
                    m0_dat_o = s_dat_i;
                end
                M_DCACHE: begin
                    s_cyc_o  = m1_cyc_i;
                    s_stb_o  = m1_stb_i;
                    s_we_o   = m1_we_i;
                    s_adr_o  = m1_adr_i;
                    s_dat_o  = m1_dat_i;
                    s_sel_o  = m1_sel_i;
                    s_bl_o   = m1_bl_i;
                    s_bry_o  = m1_bry_i;
                    m1_ack_o = s_ack_i;
                    m1_dat_o = s_dat_i;
                end
                M_OTHERS: begin
                    s_cyc_o  = m2_cyc_i;
                    s_stb_o  = m2_stb_i;
                    s_we_o   = m2_we_i;
                    s_adr_o  = m2_adr_i;
                    s_dat_o  = m2_dat_i;
                    s_sel_o  = m2_sel_i;
                    s_bl_o   = BL_W'(1);
                    s_bry_o  = 1'b1;
                    m2_ack_o = s_ack_i;
                    m2_dat_o = s_dat_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_l1_mem_burst_arbiter.sv
// Self-checking bench for l1_mem_burst_arbiter: directed transactions with a
// scoreboard of expected acknowledges (owner, read data).
module tb_l1_mem_burst_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_cyc_i, m0_stb_i, m0_bry_i, m0_ack_o;
    logic [31:0] m0_adr_i, m0_dat_o;
    logic [9:0]  m0_bl_i;
    logic        m1_cyc_i, m1_stb_i, m1_we_i, m1_bry_i, m1_ack_o;
    logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
    logic [3:0]  m1_sel_i;
    logic [9:0]  m1_bl_i;
    logic        m2_cyc_i, m2_stb_i, m2_we_i, m2_ack_o;
    logic [31:0] m2_adr_i, m2_dat_i, m2_dat_o;
    logic [3:0]  m2_sel_i;
    logic        s_cyc_o, s_stb_o, s_we_o, s_bry_o, s_ack_i;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic [9:0]  s_bl_o;
    logic [1:0]  grant_o;

    typedef struct packed {
        logic [1:0]  m;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   mon_n;
    logic [1:0]  mon_m;
    logic [31:0] mon_d;
    exp_t mon_e;

    l1_mem_burst_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_adr_i(m0_adr_i), .m0_bl_i(m0_bl_i),
        .m0_bry_i(m0_bry_i), .m0_ack_o(m0_ack_o), .m0_dat_o(m0_dat_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_bl_i(m1_bl_i), .m1_bry_i(m1_bry_i),
        .m1_ack_o(m1_ack_o), .m1_dat_o(m1_dat_o),
        .m2_cyc_i(m2_cyc_i), .m2_stb_i(m2_stb_i), .m2_we_i(m2_we_i), .m2_adr_i(m2_adr_i),
        .m2_dat_i(m2_dat_i), .m2_sel_i(m2_sel_i), .m2_ack_o(m2_ack_o), .m2_dat_o(m2_dat_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_bl_o(s_bl_o), .s_bry_o(s_bry_o),
        .s_ack_i(s_ack_i), .s_dat_i(s_dat_i), .grant_o(grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every forwarded ack must match the next scoreboard entry.
    always @(negedge clk) begin
        mon_n = int'(m0_ack_o) + int'(m1_ack_o) + int'(m2_ack_o);
        if (mon_n > 1) check_eq("ack_onehot", mon_n, 1);
        if (mon_n == 1) begin
            mon_m = m0_ack_o ? 2'd0 : (m1_ack_o ? 2'd1 : 2'd2);
            mon_d = m0_ack_o ? m0_dat_o : (m1_ack_o ? m1_dat_o : m2_dat_o);
            if (exp_q.size() == 0) begin
                check_eq("ack_unexpected", mon_m, 3);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("ack_master", mon_m, mon_e.m);
                check_eq("ack_data", mon_d, mon_e.d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drop(input logic [1:0] m);
        case (m)
            2'd0: begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
            2'd1: begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
            default: begin m2_cyc_i = 1'b0; m2_stb_i = 1'b0; end
        endcase
    endtask

    task automatic await_grant(input logic [1:0] m, input string tag);
        int waited = 0;
        @(negedge clk);
        while (grant_o == 2'd3 && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check_eq(tag, grant_o, m);
        check_eq({tag, "_cyc"}, s_cyc_o, 1);
    endtask

    task automatic run_beats(input logic [1:0] m, input int n, input logic [31:0] base);
        logic [31:0] oth;
        for (int i = 0; i < n; i++) begin
            step();
            s_ack_i = 1'b1;
            s_dat_i = base + 32'(i);
            exp_q.push_back('{m: m, d: base + 32'(i)});
            @(negedge clk);
            check_eq("beat_grant", grant_o, m);
            oth = ((m == 2'd0) ? 32'h0 : m0_dat_o) | ((m == 2'd1) ? 32'h0 : m1_dat_o) |
                  ((m == 2'd2) ? 32'h0 : m2_dat_o);
            check_eq("other_dat", oth, 0);
        end
        step();
        s_ack_i = 1'b0;
        s_dat_i = '0;
        drop(m);
        @(negedge clk);
        check_eq("done_cyc", s_cyc_o, 0);
        check_eq("done_grant", grant_o, 3);
    endtask

    initial begin
        reset = 1'b1;
        {m0_cyc_i, m0_stb_i, m0_bry_i} = '0; m0_adr_i = '0; m0_bl_i = '0;
        {m1_cyc_i, m1_stb_i, m1_we_i, m1_bry_i} = '0; m1_adr_i = '0; m1_dat_i = '0;
        m1_sel_i = '0; m1_bl_i = '0;
        {m2_cyc_i, m2_stb_i, m2_we_i} = '0; m2_adr_i = '0; m2_dat_i = '0; m2_sel_i = '0;
        s_ack_i = 1'b0; s_dat_i = '0;
        step(); step();
        @(negedge clk);
        check_eq("rst_grant", grant_o, 3);
        check_eq("rst_cyc", s_cyc_o, 0);
        check_eq("rst_acks", {m0_ack_o, m1_ack_o, m2_ack_o}, 0);
        check_eq("rst_adr", s_adr_o, 0);
        step();
        reset = 1'b0;

        // single others write, one cycle arbitration latency
        step();
        m2_cyc_i = 1'b1; m2_stb_i = 1'b1; m2_we_i = 1'b1;
        m2_adr_i = 32'h3000_0010; m2_dat_i = 32'hDEAD_BEEF; m2_sel_i = 4'hF;
        @(negedge clk);
        check_eq("t1_lat_cyc", s_cyc_o, 0);
        check_eq("t1_lat_grant", grant_o, 3);
        step();
        s_ack_i = 1'b1; s_dat_i = 32'h1111_2222;
        exp_q.push_back('{m: 2'd2, d: 32'h1111_2222});
        @(negedge clk);
        check_eq("t1_grant", grant_o, 2);
        check_eq("t1_cyc", s_cyc_o, 1);
        check_eq("t1_stb", s_stb_o, 1);
        check_eq("t1_we", s_we_o, 1);
        check_eq("t1_adr", s_adr_o, 32'h3000_0010);
        check_eq("t1_dat", s_dat_o, 32'hDEAD_BEEF);
        check_eq("t1_sel", s_sel_o, 4'hF);
        check_eq("t1_bl", s_bl_o, 1);
        check_eq("t1_bry", s_bry_o, 1);
        step();
        s_ack_i = 1'b0; s_dat_i = '0; drop(2'd2); m2_we_i = 1'b0;
        @(negedge clk);
        check_eq("t1_done_cyc", s_cyc_o, 0);
        check_eq("t1_done_grant", grant_o, 3);

        // icache burst of 8
        step();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_bry_i = 1'b1;
        m0_adr_i = 32'h0000_4000; m0_bl_i = 10'd8;
        await_grant(2'd0, "t2_grant");
        check_eq("t2_we", s_we_o, 0);
        check_eq("t2_sel", s_sel_o, 4'hF);
        check_eq("t2_sdat", s_dat_o, 0);
        check_eq("t2_bl", s_bl_o, 8);
        check_eq("t2_adr", s_adr_o, 32'h0000_4000);
        run_beats(2'd0, 8, 32'hA000_0000);

        // all three at once after reset: round-robin 0, 1, 2
        step(); reset = 1'b1;
        step(); reset = 1'b0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_bl_i = 10'd4; m0_adr_i = 32'h0000_5000;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_bl_i = 10'd4; m1_bry_i = 1'b1;
        m1_adr_i = 32'h0001_0000; m1_sel_i = 4'hF;
        m2_cyc_i = 1'b1; m2_stb_i = 1'b1; m2_we_i = 1'b0; m2_adr_i = 32'h3000_0020;
        await_grant(2'd0, "t3_grant0");
        run_beats(2'd0, 4, 32'hB000_0000);
        await_grant(2'd1, "t3_grant1");
        run_beats(2'd1, 4, 32'hB100_0000);
        await_grant(2'd2, "t3_grant2");
        run_beats(2'd2, 1, 32'hB200_0000);

        // dcache abort after two beats with others pending
        step();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_bl_i = 10'd4; m1_adr_i = 32'h0002_0000;
        await_grant(2'd1, "t4_grant1");
        step();
        m2_cyc_i = 1'b1; m2_stb_i = 1'b1; m2_adr_i = 32'h3000_0030;
        s_ack_i = 1'b1; s_dat_i = 32'hC000_0000;
        exp_q.push_back('{m: 2'd1, d: 32'hC000_0000});
        @(negedge clk);
        step();
        s_dat_i = 32'hC000_0001;
        exp_q.push_back('{m: 2'd1, d: 32'hC000_0001});
        @(negedge clk);
        step();
        s_ack_i = 1'b0; drop(2'd1);
        @(negedge clk);
        check_eq("t4_abort_cyc", s_cyc_o, 0);
        check_eq("t4_abort_m1ack", m1_ack_o, 0);
        step();
        s_ack_i = 1'b1; s_dat_i = 32'hC0DE_0BAD;
        @(negedge clk);
        check_eq("t4_done_grant", grant_o, 3);
        check_eq("t4_late_ack", {m0_ack_o, m1_ack_o, m2_ack_o}, 0);
        step();
        s_ack_i = 1'b0; s_dat_i = '0;
        await_grant(2'd2, "t4_grant2");
        run_beats(2'd2, 1, 32'hC200_0000);

        // reset on beat 3 of a dcache burst of 8
        step();
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_bl_i = 10'd8; m1_adr_i = 32'h0003_0000;
        await_grant(2'd1, "t5_grant1");
        for (int i = 0; i < 2; i++) begin
            step();
            s_ack_i = 1'b1; s_dat_i = 32'hD000_0000 + 32'(i);
            exp_q.push_back('{m: 2'd1, d: 32'hD000_0000 + 32'(i)});
            @(negedge clk);
        end
        step();
        reset = 1'b1; s_dat_i = 32'hD000_0002;
        @(negedge clk);
        check_eq("t5_rst_noack", m1_ack_o, 0);
        step();
        reset = 1'b0; s_ack_i = 1'b0; s_dat_i = '0;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_bl_i = 10'd1; m0_adr_i = 32'h0000_6000;
        m1_bl_i = 10'd0; m1_adr_i = 32'h0004_0000;
        @(negedge clk);
        check_eq("t5_post_cyc", s_cyc_o, 0);
        check_eq("t5_post_stb", s_stb_o, 0);
        check_eq("t5_post_adr", s_adr_o, 0);
        check_eq("t5_post_grant", grant_o, 3);
        check_eq("t5_post_acks", {m0_ack_o, m1_ack_o, m2_ack_o}, 0);
        await_grant(2'd0, "t5_grant0");
        run_beats(2'd0, 1, 32'hE000_0000);

        // dcache bl=0 is a single beat
        await_grant(2'd1, "t6_grant1");
        run_beats(2'd1, 1, 32'hF000_0000);

        step(); step();
        check_eq("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
